// File: rtl/ws2812_if.sv
// Colour/enable input and serial-line status bundle between the
// frame controller (master) and the WS2812 driver (slave).
interface ws2812_if;
    logic        EN;
    logic [23:0] color;
    logic        DOUT;
    logic        busy;
    logic        frame_done;

    modport master (
        output EN,
        output color,
        input  DOUT,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  EN,
        input  color,
        output DOUT,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/ws2812_driver.sv
// Single-wire WS2812 frame serialiser: one latched colour to NUM_LEDS LEDs.
// WS_GRB_ORDER_EN selects the {G,R,B} latch order; default is {R,G,B}.
module ws2812_driver #(
    parameter int NUM_LEDS = 8,
    parameter int T_BIT    = 63,
    parameter int T0H      = 20,
    parameter int T1H      = 40,
    parameter int T_RES    = 2600
) (
    input  logic     CLK,
    input  logic     RST_N,
    ws2812_if.slave  bus
);

    localparam int CW = $clog2(T_BIT);
    localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int GW = (T_RES > 1) ? $clog2(T_RES) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(T_BIT - 1);
    localparam logic [CW-1:0] TH0      = CW'(T0H);
    localparam logic [CW-1:0] TH1      = CW'(T1H);
    localparam logic [LW-1:0] LED_LAST = LW'(NUM_LEDS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(T_RES - 1);
    localparam logic [GW-1:0] GAP_PREV = GW'(T_RES - 2);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t        state;
    logic [23:0]   latch;
    logic [CW-1:0] cyc_cnt;
    logic [4:0]    bit_cnt;
    logic [LW-1:0] led_cnt;
    logic [GW-1:0] gap_cnt;
    logic          dout_q;
    logic          busy_q;
    logic          done_q;

    logic [23:0]   word_in;
    logic          last_cyc;
    logic          last_bit;
    logic          last_led;
    logic          last_gap;
    logic [CW-1:0] cyc_nx;
    logic [4:0]    bit_nx;
    logic          hi_nx;

`ifdef WS_GRB_ORDER_EN
    assign word_in = {bus.color[15:8], bus.color[23:16], bus.color[7:0]};
`else
    assign word_in = bus.color;
`endif

    // DOUT is registered, so the level for the upcoming cycle is
    // derived from the counter values that cycle will hold.
    always_comb begin
        last_cyc = (cyc_cnt == CYC_LAST);
        last_bit = (bit_cnt == 5'd23);
        last_led = (led_cnt == LED_LAST);
        last_gap = (gap_cnt == GAP_LAST);
        cyc_nx   = last_cyc ? '0 : cyc_cnt + CW'(1);
        bit_nx   = bit_cnt;
        if (last_cyc) begin
            bit_nx = last_bit ? 5'd0 : bit_cnt + 5'd1;
        end
        hi_nx = latch[5'd23 - bit_nx] ? (cyc_nx < TH1)
                                      : (cyc_nx < TH0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            latch   <= '0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            led_cnt <= '0;
            gap_cnt <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    dout_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.EN) begin
                        state   <= SEND;
                        latch   <= word_in;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        led_cnt <= '0;
                        dout_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                SEND: begin
                    cyc_cnt <= cyc_nx;
                    bit_cnt <= bit_nx;
                    dout_q  <= hi_nx;
                    if (last_cyc && last_bit) begin
                        if (last_led) begin
                            state   <= GAP;
                            led_cnt <= '0;
                            gap_cnt <= '0;
                            dout_q  <= 1'b0;
                            done_q  <= (T_RES == 1);
                        end else begin
                            led_cnt <= led_cnt + LW'(1);
                        end
                    end
                end
                GAP: begin
                    dout_q <= 1'b0;
                    if (last_gap) begin
                        gap_cnt <= '0;
                        if (bus.EN) begin
                            state   <= SEND;
                            latch   <= word_in;
                            cyc_cnt <= '0;
                            bit_cnt <= '0;
                            led_cnt <= '0;
                            dout_q  <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                        done_q  <= (T_RES > 1) &&
                                   (gap_cnt == GAP_PREV);
                    end
                end
                default: begin
                    state  <= IDLE;
                    dout_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DOUT       = dout_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule
